// File: rtl/conv_mdc_tile_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_mdc_tile_sched_if
// Purpose  : Streamer-facing handshake and tile-descriptor bundle for the
//            conv_mdc tile scheduler. The master side is the scheduler, the
//            slave side is the src_V/dst_V streamer pair.
// Revision : 1.0 - initial release
// ============================================================================
interface conv_mdc_tile_sched_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) ();

  // Streamer status towards the scheduler
  logic                  src_ready_start_i;
  logic                  dst_ready_start_i;
  logic                  src_done_i;
  logic                  dst_done_i;

  // Start strobes and current tile descriptor towards the streamers
  logic                  src_req_start_o;
  logic                  dst_req_start_o;
  logic [ADDR_WIDTH-1:0] src_addr_o;
  logic [ADDR_WIDTH-1:0] dst_addr_o;
  logic [CNT_WIDTH-1:0]  len_o;
  logic [CNT_WIDTH-1:0]  tile_idx_o;

  modport master (
    input  src_ready_start_i, dst_ready_start_i, src_done_i, dst_done_i,
    output src_req_start_o, dst_req_start_o, src_addr_o, dst_addr_o,
           len_o, tile_idx_o
  );

  modport slave (
    output src_ready_start_i, dst_ready_start_i, src_done_i, dst_done_i,
    input  src_req_start_o, dst_req_start_o, src_addr_o, dst_addr_o,
           len_o, tile_idx_o
  );

endinterface
`default_nettype wire

// File: rtl/conv_mdc_tile_sched.sv
`default_nettype none
// ============================================================================
// Module   : conv_mdc_tile_sched
// Purpose  : Splits one conv_mdc job into n_tiles back-to-back tiles. Each
//            tile launches the source and sink streamers together, waits for
//            both completions, then advances both TCDM addresses by their
//            strides. End of job is flagged with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module conv_mdc_tile_sched #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  wire                    clk_i,
  input  wire                    rst_ni,
  input  wire                    clear_i,
  input  wire                    start_i,
  input  wire [ADDR_WIDTH-1:0]   src_base_i,
  input  wire [ADDR_WIDTH-1:0]   dst_base_i,
  input  wire [ADDR_WIDTH-1:0]   src_stride_i,
  input  wire [ADDR_WIDTH-1:0]   dst_stride_i,
  input  wire [CNT_WIDTH-1:0]    tile_len_i,
  input  wire [CNT_WIDTH-1:0]    n_tiles_i,
  output logic                   busy_o,
  output logic                   done_o,
  conv_mdc_tile_sched_if.master  strm
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_NEXT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_src_addr;
  logic [ADDR_WIDTH-1:0] r_dst_addr;
  logic [ADDR_WIDTH-1:0] r_src_stride;
  logic [ADDR_WIDTH-1:0] r_dst_stride;
  logic [CNT_WIDTH-1:0]  r_len;
  logic [CNT_WIDTH-1:0]  r_n_tiles;
  logic [CNT_WIDTH-1:0]  r_tile_idx;
  logic                  r_src_seen;
  logic                  r_dst_seen;

  logic                  w_launch;
  logic                  w_pair_done;
  logic                  w_last_tile;
  logic                  w_degenerate;

  // Launch strobe is Mealy on the ready pair so both streamers start in the
  // same cycle; a soft clear suppresses it. A done pulse arriving in the same
  // cycle as the sticky partner flag completes the pair without waiting.
  always_comb begin
    w_launch     = (r_state == S_LAUNCH) && strm.src_ready_start_i &&
                   strm.dst_ready_start_i && !clear_i;
    w_pair_done  = (r_src_seen || strm.src_done_i) &&
                   (r_dst_seen || strm.dst_done_i);
    w_last_tile  = (r_tile_idx == (r_n_tiles - C_CNT_ONE));
    w_degenerate = (n_tiles_i == '0) || (tile_len_i == '0);
  end

  // Tile sequencing FSM with its address/index counters and completion flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_src_addr   <= '0;
      r_dst_addr   <= '0;
      r_src_stride <= '0;
      r_dst_stride <= '0;
      r_len        <= '0;
      r_n_tiles    <= '0;
      r_tile_idx   <= '0;
      r_src_seen   <= 1'b0;
      r_dst_seen   <= 1'b0;
    end else if (clear_i) begin
      r_state      <= S_IDLE;
      r_src_addr   <= '0;
      r_dst_addr   <= '0;
      r_src_stride <= '0;
      r_dst_stride <= '0;
      r_len        <= '0;
      r_n_tiles    <= '0;
      r_tile_idx   <= '0;
      r_src_seen   <= 1'b0;
      r_dst_seen   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_src_addr   <= src_base_i;
            r_dst_addr   <= dst_base_i;
            r_src_stride <= src_stride_i;
            r_dst_stride <= dst_stride_i;
            r_len        <= tile_len_i;
            r_n_tiles    <= n_tiles_i;
            r_tile_idx   <= '0;
            r_state      <= w_degenerate ? S_DONE : S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (w_launch) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_pair_done) begin
            r_src_seen <= 1'b0;
            r_dst_seen <= 1'b0;
            r_state    <= S_NEXT;
          end else begin
            r_src_seen <= r_src_seen | strm.src_done_i;
            r_dst_seen <= r_dst_seen | strm.dst_done_i;
          end
        end
        S_NEXT: begin
          if (w_last_tile) begin
            r_state <= S_DONE;
          end else begin
            r_tile_idx <= r_tile_idx + C_CNT_ONE;
            r_src_addr <= r_src_addr + r_src_stride;
            r_dst_addr <= r_dst_addr + r_dst_stride;
            r_state    <= S_LAUNCH;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output mapping: descriptor fields come straight from registers
  always_comb begin
    strm.src_req_start_o = w_launch;
    strm.dst_req_start_o = w_launch;
    strm.src_addr_o      = r_src_addr;
    strm.dst_addr_o      = r_dst_addr;
    strm.len_o           = r_len;
    strm.tile_idx_o      = r_tile_idx;
    busy_o               = (r_state != S_IDLE);
    done_o               = (r_state == S_DONE);
  end

endmodule
`default_nettype wire

// File: doc/conv_mdc_tile_sched.md
# conv_mdc_tile_sched

Tile scheduler for the conv_mdc HWPE. It sits between the control register file and the streamer/engine pair, and splits one job into `n_tiles` back-to-back tiles. For each tile it launches the src_V source and dst_V sink streamers together, waits until both report completion, and advances the TCDM addresses by a per-stream stride. It signals the end of the job to the controller with a one-cycle done pulse, which feeds the event line.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: width of the TCDM byte addresses.
- `CNT_WIDTH`, default 16: width of the tile length and tile count fields.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock, asynchronous, active-low.
- `clear_i`  in  1  synchronous soft clear from the controller.
- `start_i`  in  1  job trigger, one-cycle pulse.
- `src_base_i`  in  ADDR_WIDTH  first source address.
- `dst_base_i`  in  ADDR_WIDTH  first sink address.
- `src_stride_i`  in  ADDR_WIDTH  per-tile source address increment.
- `dst_stride_i`  in  ADDR_WIDTH  per-tile sink address increment.
- `tile_len_i`  in  CNT_WIDTH  words per tile.
- `n_tiles_i`  in  CNT_WIDTH  tiles per job.
- `src_ready_start_i`  in  1  source streamer idle and able to accept a start.
- `dst_ready_start_i`  in  1  sink streamer idle and able to accept a start.
- `src_done_i`  in  1  source streamer done, one-cycle pulse.
- `dst_done_i`  in  1  sink streamer done, one-cycle pulse.
- `src_req_start_o`  out  1  source streamer start strobe.
- `dst_req_start_o`  out  1  sink streamer start strobe.
- `src_addr_o`  out  ADDR_WIDTH  current tile source address.
- `dst_addr_o`  out  ADDR_WIDTH  current tile sink address.
- `len_o`  out  CNT_WIDTH  current tile length.
- `tile_idx_o`  out  CNT_WIDTH  index of the current tile.
- `busy_o`  out  1  job in progress.
- `done_o`  out  1  job complete, one-cycle pulse.

## Operation
- States: IDLE, LAUNCH, RUN, NEXT, DONE.
- **IDLE**
  - On `start_i`, latch the strides, `tile_len_i` and `n_tiles_i`.
  - Load `src_addr_o` from `src_base_i` and `dst_addr_o` from `dst_base_i`; set `tile_idx_o` to 0.
  - If `n_tiles_i==0` or `tile_len_i==0`, go to DONE. Otherwise go to LAUNCH.
- **LAUNCH**
  - `src_req_start_o` and `dst_req_start_o` are both equal to (LAUNCH && `src_ready_start_i` && `dst_ready_start_i`). This is a Mealy output, and the two strobes always assert in the same cycle.
  - The strobe cycle moves the FSM to RUN. Otherwise it stays in LAUNCH and stalls indefinitely.
- **RUN**
  - Sticky flags `src_seen` and `dst_seen` are set by the matching done pulses; either order is allowed, as is the same cycle.
  - The transition to NEXT happens in the first cycle where (`src_seen` || `src_done_i`) && (`dst_seen` || `dst_done_i`).
  - Both flags are cleared on the transition to NEXT.
- **NEXT**
  - If `tile_idx_o == n_tiles-1`, go to DONE and leave the counters unchanged.
  - Otherwise increment `tile_idx_o`, add the latched strides to both addresses, and go to LAUNCH.
- **DONE**: `done_o`=1 for exactly one cycle, then IDLE.
- `busy_o` = (state != IDLE).
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent. The stride value is unsigned.
- `len_o` holds the latched tile length for the whole job.
- `start_i` outside IDLE is ignored; it is not queued.
- Done pulses arriving outside RUN are ignored and do not set the sticky flags.
- `clear_i` has priority over every transition. In the next cycle:
  - state is IDLE, all counters, addresses and flags are 0;
  - no `done_o` pulse is produced, and no start strobe is issued in the clear cycle.

## Timing
- Reset values: every output is 0 and state is IDLE. Asynchronous reset mid-job aborts it with no done pulse.
- `start_i` sampled at edge t: `busy_o`=1 and state is LAUNCH from t+1. The first strobe occurs at t+1 if both ready inputs are high.
- A done pair completing in cycle c gives NEXT at c+1 and, for a middle tile, the next strobe at c+2 at the earliest. Scheduler overhead is therefore 2 cycles per tile.
- The last tile's done pair at c gives `done_o` at c+2 and `busy_o`=0 at c+3.
- A zero-length job: `start_i` at t gives `done_o` at t+1.
- The address and length outputs are registered and stable throughout LAUNCH and RUN.

## Test plan
- **Single tile.** Stimulus: `src_base`=0x100, `dst_base`=0x200, `tile_len`=8, `n_tiles`=1, both ready high, both done pulses 10 cycles after the strobe. Required: one strobe with addresses 0x100/0x200 and `len_o`=8; `done_o` 2 cycles after the done pair; `busy_o` low afterwards.
- **Multi-tile with strides.** Stimulus: `n_tiles`=3, `src_stride`=0x20, `dst_stride`=0x40. Required: strobes carry `src_addr_o` 0x100/0x120/0x140, `dst_addr_o` 0x200/0x240/0x280 and `tile_idx_o` 0/1/2; exactly one `done_o` pulse.
- **Completion order and ready stall.** Stimulus: `dst_done` 3 cycles before `src_done`; then both done in the same cycle; then `dst_ready_start_i` held low for 5 cycles in LAUNCH. Required: NEXT is entered only after both dones are seen; no strobe is issued during the stall; the strobes stay simultaneous.
- **Degenerate jobs.** Stimulus: `n_tiles`=0, then `tile_len`=0 with `n_tiles`=4. Required: no strobes; `done_o` at t+1 in both cases.
- **Clear and reset mid-job.** Stimulus: `clear_i` in RUN of tile 1, then a new job; in a separate run, `rst_ni` low during LAUNCH. Required: IDLE with zeroed outputs, no `done_o`; the new job starts from `tile_idx`=0 at its own base addresses.
- **Ignored inputs and wrap-around.** Stimulus: `start_i` re-pulsed while busy; a stray `src_done_i` pulse in IDLE; `src_base`=0xFFFF_FFF0 with stride 0x20. Required: no effect from the re-pulse or the stray done; second-tile `src_addr_o`=0x0000_0010.
